lenet_argmax_stream: RTL and testbench
======================================

Name: lenet_argmax_stream

Overview:
- Streaming classifier back-end for the LeNet accelerator.
- Accepts class scores one per beat over a valid/ready handshake and tracks the running maximum and its index.
- At frame end, emits a registered result: index, one-hot, max value and a length-error flag.
- Keeps a persistent LED one-hot register, so it generalises the fixed 10-class combinational argmax to any class count and width, with back-pressure.

Parameters:
- DATA_W, 8, signed score width.
- NUM_CLASSES, 10, scores per frame (>=2).
- IDX_W, $clog2(NUM_CLASSES), index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  score beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  DATA_W  signed score
- in_last  in  1  final beat of frame
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_index  out  IDX_W  argmax class index
- out_onehot  out  NUM_CLASSES  one-hot of out_index
- out_max  out  DATA_W  signed winning score (post-clamp if enabled)
- out_len_err  out  1  frame length did not equal NUM_CLASSES
- led  out  NUM_CLASSES  one-hot of last consumed result, held

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, beat count=0, running max/index=0.
  - out_valid=0, out_index=0, out_onehot=0, out_max=0, out_len_err=0, led=0.
  - in_ready=0 while reset_n=0.
- FSM states IDLE, ACCUM, HOLD.
  - in_ready=1 in IDLE and ACCUM; 0 in HOLD.
- Beat accepted = in_valid & in_ready.
- IDLE: accepted beat loads max=score, index=0, count=1, goes to ACCUM. If that beat has in_last, it goes directly to HOLD as a 1-beat frame.
- ACCUM: accepted beat compares score > max (strict, signed). If true, max=score and index=count. Then count++.
- Ties: the lowest index wins, because the comparison is strict.
- Frame end is the earlier of: in_last on an accepted beat, or the accepted beat with count==NUM_CLASSES-1.
  - At frame end, results register, out_valid=1 the next cycle, and the state goes to HOLD.
  - Latency is 1 cycle from the final accepted beat to out_valid.
- out_len_err=1 when:
  - in_last arrives with count<NUM_CLASSES-1 (short frame), or
  - beat NUM_CLASSES-1 arrives without in_last (frame truncated). Subsequent beats belong to the next frame.
- HOLD:
  - Outputs stable while out_ready=0.
  - On out_valid & out_ready: led<=out_onehot, out_valid<=0, state goes to IDLE, count clears. in_ready returns the following cycle; there is no same-cycle turnaround.
- out_onehot is registered together with out_index and is always exactly one-hot while out_valid=1.
- led updates only on a result handshake. It is never cleared except by reset.
- Reset mid-frame: partial frame discarded, no result produced.
- Reset mid-HOLD: result lost, led=0.
- Widths: comparisons are signed DATA_W; index arithmetic is IDX_W, with no wrap since count never exceeds NUM_CLASSES-1.

Optional Feature:
RELU_CLAMP_EN
- Defined: each in_data has a ReLU clamp applied before comparison (negative becomes 0).
  - An all-negative frame yields index 0, max 0.
  - out_max is never negative.
- Undefined: raw signed scores are compared.
  - An all-negative frame yields the least negative score's index.
  - out_max carries that signed value.

Test Plan:
1. Frame [3,-2,7,1,0,5,7,-8,2,4] with last on beat 9, out_ready=1 -> out_valid 1 cycle after beat 9, index=2, onehot=10'b0000000100, max=7, len_err=0. After handshake led=10'b0000000100.
2. All -5 except beat 6=-1:
   - Without RELU_CLAMP_EN -> index=6, max=-1.
   - With RELU_CLAMP_EN -> index=0, max=0.
3. Back-pressure: out_ready=0 for 5 cycles after result -> in_ready=0 and outputs stable throughout. Next frame is accepted only after the handshake cycle.
4. Short frame: 4 beats [1,9,2,3] with last on beat 3 -> index=1, max=9, len_err=1.
5. Truncation: 12 beats with no in_last, values 0..11 -> first result index=9, max=9, len_err=1. Beats 10,11 start the next frame (index=1, max=11 once in_last is given on beat 11).
6. Reset asserted async mid-ACCUM (after beat 4) and in HOLD -> all outputs 0 immediately. No out_valid until a fresh full frame completes.

Source files
------------

// File: rtl/lenet_argmax_stream.sv
// Streaming argmax back-end: tracks the running signed maximum of NUM_CLASSES scores per frame.
// Optional RELU_CLAMP_EN: negative scores are clamped to zero before comparison.
module lenet_argmax_stream #(
  parameter  int DATA_W      = 8,
  parameter  int NUM_CLASSES = 10,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_index,
  output logic [NUM_CLASSES-1:0] out_onehot,
  output logic [DATA_W-1:0]      out_max,
  output logic                   out_len_err,
  output logic [NUM_CLASSES-1:0] led
);

  // state | meaning
  // IDLE  | waiting for the first beat of a frame
  // ACCUM | comparing beats 1..NUM_CLASSES-1 against the running max
  // HOLD  | result registered, waiting for the consumer
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         count_q, count_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic                     out_valid_q, out_valid_d;
  logic [IDX_W-1:0]         out_index_q, out_index_d;
  logic [NUM_CLASSES-1:0]   out_onehot_q, out_onehot_d;
  logic signed [DATA_W-1:0] out_max_q, out_max_d;
  logic                     out_len_err_q, out_len_err_d;
  logic [NUM_CLASSES-1:0]   led_q, led_d;

  logic signed [DATA_W-1:0] score;
  logic signed [DATA_W-1:0] win_max;
  logic [IDX_W-1:0]         beat_idx, win_idx;
  logic                     accept, better, frame_end, last_beat_pos;

`ifdef RELU_CLAMP_EN
  assign score = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign score = in_data;
`endif

  assign in_ready = reset_n && (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    idx_d         = idx_q;
    max_d         = max_q;
    out_valid_d   = out_valid_q;
    out_index_d   = out_index_q;
    out_onehot_d  = out_onehot_q;
    out_max_d     = out_max_q;
    out_len_err_d = out_len_err_q;
    led_d         = led_q;

    // First beat of a frame always wins; later beats need a strictly greater score.
    beat_idx      = (state_q == IDLE) ? '0 : count_q;
    better        = (state_q == IDLE) || (score > max_q);
    win_idx       = better ? beat_idx : idx_q;
    win_max       = better ? score : max_q;
    last_beat_pos = (beat_idx == IDX_W'(NUM_CLASSES - 1));
    frame_end     = in_last || last_beat_pos;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          idx_d   = win_idx;
          max_d   = win_max;
          count_d = beat_idx + IDX_W'(1);
          state_d = ACCUM;
          if (frame_end) begin
            state_d       = HOLD;
            count_d       = '0;
            out_valid_d   = 1'b1;
            out_index_d   = win_idx;
            out_max_d     = win_max;
            out_len_err_d = !(in_last && last_beat_pos);
            for (int i = 0; i < NUM_CLASSES; i++) begin
              out_onehot_d[i] = (win_idx == IDX_W'(i));
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          led_d       = out_onehot_q;
          out_valid_d = 1'b0;
          count_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      max_q         <= '0;
      out_valid_q   <= 1'b0;
      out_index_q   <= '0;
      out_onehot_q  <= '0;
      out_max_q     <= '0;
      out_len_err_q <= 1'b0;
      led_q         <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      max_q         <= max_d;
      out_valid_q   <= out_valid_d;
      out_index_q   <= out_index_d;
      out_onehot_q  <= out_onehot_d;
      out_max_q     <= out_max_d;
      out_len_err_q <= out_len_err_d;
      led_q         <= led_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign out_onehot  = out_onehot_q;
  assign out_max     = out_max_q;
  assign out_len_err = out_len_err_q;
  assign led         = led_q;

endmodule

// File: tb/tb_lenet_argmax_stream.sv
// Self-checking bench for lenet_argmax_stream: scoreboard of expected frame results plus
// scenario tasks for latency, back-pressure, length errors and async reset.
module tb_lenet_argmax_stream;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_len_err;
  logic [3:0] out_index;
  logic [9:0] out_onehot, led;
  logic [7:0] out_max;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] idx;
    logic [9:0] oh;
    logic [7:0] mx;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  lenet_argmax_stream #(.DATA_W(8), .NUM_CLASSES(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_onehot (out_onehot),
    .out_max    (out_max),
    .out_len_err(out_len_err),
    .led        (led)
  );

  always #5 clk = ~clk;

  function automatic int clampf(input int x);
`ifdef RELU_CLAMP_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic exp_t model(input int v[$], input bit last_given);
    exp_t e;
    int best, bi, s;
    best = clampf(v[0]);
    bi   = 0;
    foreach (v[i]) begin
      s = clampf(v[i]);
      if (s > best) begin
        best = s;
        bi   = i;
      end
    end
    e.idx     = 4'(bi);
    e.oh      = '0;
    e.oh[bi]  = 1'b1;
    e.mx      = 8'(best);
    e.err     = !(last_given && v.size() == 10);
    return e;
  endfunction

  // Scoreboard: results are compared when the consumer side completes a handshake.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected index=%0d max=%0d", out_index, $signed(out_max));
      end else begin
        mon_e = sb.pop_front();
        if (out_index !== mon_e.idx) begin
          failures++;
          $display("FAIL sb_index got=%0d exp=%0d", out_index, mon_e.idx);
        end
        checks++;
        if (out_onehot !== mon_e.oh) begin
          failures++;
          $display("FAIL sb_onehot got=%b exp=%b", out_onehot, mon_e.oh);
        end
        checks++;
        if (out_max !== mon_e.mx) begin
          failures++;
          $display("FAIL sb_max got=%0d exp=%0d", $signed(out_max), $signed(mon_e.mx));
        end
        checks++;
        if (out_len_err !== mon_e.err) begin
          failures++;
          $display("FAIL sb_len_err got=%b exp=%b", out_len_err, mon_e.err);
        end
      end
    end
  end

  // Must be called at a negedge; returns at the negedge following the last accepted beat.
  task automatic send_frame(input int v[$], input int last_at);
    int n;
    foreach (v[i]) begin
      in_valid = 1'b1;
      in_data  = 8'(v[i]);
      in_last  = (i == last_at);
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (!in_ready) begin
        failures++;
        $display("FAIL beat_accept_timeout beat=%0d in_ready=%b", i, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_result_timeout pending=%0d exp=0", name, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_index !== 4'd0 || out_onehot !== 10'd0 ||
        out_max !== 8'd0 || out_len_err !== 1'b0 || led !== 10'd0) begin
      failures++;
      $display("FAIL reset_values rdy=%b vld=%b idx=%0d oh=%b max=%0d err=%b led=%b exp=all_zero",
               in_ready, out_valid, out_index, out_onehot, out_max, out_len_err, led);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_basic;
    int v[$] = '{3, -2, 7, 1, 0, 5, 7, -8, 2, 4};
    sb.push_back(model(v, 1'b1));
    out_ready = 1'b1;
    send_frame(v, 9);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency out_valid=%b exp=1", out_valid);
    end
    @(negedge clk);
    checks++;
    if (led !== 10'b0000000100) begin
      failures++;
      $display("FAIL basic_led got=%b exp=%b", led, 10'b0000000100);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
    end
    drain("basic");
  endtask

  task automatic test_all_negative;
    int v[$] = '{-5, -5, -5, -5, -5, -5, -1, -5, -5, -5};
    sb.push_back(model(v, 1'b1));
    send_frame(v, 9);
    drain("all_negative");
  endtask

  task automatic test_back_to_back;
    int v[$]  = '{-1, 4, 4, 0, 2, 9, 9, 3, 1, 0};
    int v2[$] = '{50, 10, 60, 60, -3, 2, 0, 1, 59, 7};
    exp_t e;
    e = model(v, 1'b1);
    sb.push_back(e);
    out_ready = 1'b0;
    send_frame(v, 9);
    in_valid = 1'b1;
    in_data  = 8'd50;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_index !== e.idx || out_max !== e.mx ||
          out_onehot !== e.oh) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d rdy=%b vld=%b idx=%0d max=%0d exp=0/1/%0d/%0d",
                 c, in_ready, out_valid, out_index, $signed(out_max), e.idx, $signed(e.mx));
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_turnaround in_ready=%b exp=0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || led !== e.oh) begin
      failures++;
      $display("FAIL bp_release in_ready=%b led=%b exp=1/%b", in_ready, led, e.oh);
    end
    sb.push_back(model(v2, 1'b1));
    send_frame(v2, 9);
    drain("back_to_back");
  endtask

  task automatic test_short_frame;
    int v[$] = '{1, 9, 2, 3};
    sb.push_back(model(v, 1'b1));
    send_frame(v, 3);
    drain("short_frame");
  endtask

  task automatic test_truncation;
    int v[$];
    int a[$];
    int b[$] = '{10, 11};
    for (int i = 0; i < 12; i++) v.push_back(i);
    for (int i = 0; i < 10; i++) a.push_back(i);
    sb.push_back(model(a, 1'b0));
    sb.push_back(model(b, 1'b1));
    send_frame(v, 11);
    drain("truncation");
  endtask

  task automatic test_async_reset;
    int p[$]  = '{5, 6, 7, 8, 9};
    int f[$]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, -9};
    int g[$]  = '{2, -7, 1, 0, 1, 1, 3, 8, 4, 5};
    exp_t e;
    out_ready = 1'b1;
    send_frame(p, -1);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_index !== 4'd0 || out_onehot !== 10'd0 ||
        out_max !== 8'd0 || led !== 10'd0) begin
      failures++;
      $display("FAIL rst_accum rdy=%b vld=%b idx=%0d oh=%b max=%0d led=%b exp=all_zero",
               in_ready, out_valid, out_index, out_onehot, out_max, led);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_accum_no_result cyc=%0d out_valid=%b exp=0", c, out_valid);
      end
    end
    out_ready = 1'b0;
    send_frame(f, 9);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold_setup out_valid=%b exp=1", out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_onehot !== 10'd0 || out_index !== 4'd0 || out_max !== 8'd0 ||
        led !== 10'd0) begin
      failures++;
      $display("FAIL rst_hold vld=%b oh=%b idx=%0d max=%0d led=%b exp=all_zero",
               out_valid, out_onehot, out_index, out_max, led);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_hold_no_result cyc=%0d out_valid=%b exp=0", c, out_valid);
      end
    end
    e = model(g, 1'b1);
    sb.push_back(e);
    send_frame(g, 9);
    drain("after_reset");
    checks++;
    if (led !== e.oh) begin
      failures++;
      $display("FAIL after_reset_led got=%b exp=%b", led, e.oh);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_negative();
    test_back_to_back();
    test_short_frame();
    test_truncation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
